// File: rtl/chip_serial_tx.sv
// Framed parallel-in/serial-out transmitter: start bit (0), DATA_W data bits, stop bit (1).
// Every level is held DIV clocks. All outputs come straight from flops.
module chip_serial_tx #(
  parameter int DATA_W    = 8,
  parameter int DIV       = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              sdo,
  output logic              busy,
  output logic              done
);

  localparam int DIV_CW = $clog2(DIV) + 1;
  localparam int BIT_CW = $clog2(DATA_W) + 1;
  localparam logic [DIV_CW-1:0] DIV_LAST = DIV_CW'(DIV - 1);
  localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state, state_next;
  logic [DIV_CW-1:0]   div_cnt, div_next;
  logic [BIT_CW-1:0]   bit_cnt, bit_next;
  logic [DATA_W-1:0]   shreg, shreg_next, shifted;
  logic                sdo_next, ready_next, busy_next, done_next;

  function automatic logic out_bit(input logic [DATA_W-1:0] v);
    return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      sdo      <= 1'b1;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      div_cnt  <= div_next;
      bit_cnt  <= bit_next;
      shreg    <= shreg_next;
      sdo      <= sdo_next;
      tx_ready <= ready_next;
      busy     <= busy_next;
      done     <= done_next;
    end
  end

  // Next-state logic also computes the next value of every output so sdo lines up with the state.
  always_comb begin
    state_next = state;
    div_next   = div_cnt;
    bit_next   = bit_cnt;
    shreg_next = shreg;
    sdo_next   = sdo;
    ready_next = tx_ready;
    busy_next  = busy;
    done_next  = 1'b0;
    shifted    = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);

    case (state)
      IDLE: begin
        ready_next = 1'b1;
        busy_next  = 1'b0;
        sdo_next   = 1'b1;
        if (tx_valid && tx_ready) begin
          shreg_next = tx_data;
          state_next = START;
          div_next   = '0;
          bit_next   = '0;
          sdo_next   = 1'b0;
          ready_next = 1'b0;
          busy_next  = 1'b1;
        end
      end

      START: begin
        if (div_cnt == DIV_LAST) begin
          div_next   = '0;
          state_next = DATA;
          sdo_next   = out_bit(shreg);
        end else begin
          div_next = div_cnt + DIV_CW'(1);
        end
      end

      // The bit presented on sdo is always the output end of shreg; the next one comes from the shifted copy.
      DATA: begin
        if (div_cnt == DIV_LAST) begin
          div_next   = '0;
          shreg_next = shifted;
          if (bit_cnt == BIT_LAST) begin
            bit_next   = '0;
            state_next = STOP;
            sdo_next   = 1'b1;
          end else begin
            bit_next = bit_cnt + BIT_CW'(1);
            sdo_next = out_bit(shifted);
          end
        end else begin
          div_next = div_cnt + DIV_CW'(1);
        end
      end

      STOP: begin
        sdo_next = 1'b1;
        if (div_cnt == DIV_LAST) begin
          div_next   = '0;
          state_next = IDLE;
          ready_next = 1'b1;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end else begin
          div_next = div_cnt + DIV_CW'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_chip_serial_tx.sv
// Self-checking bench for chip_serial_tx: three instances with different DIV/MSB_FIRST,
// each frame compared cycle by cycle against the ideal waveform built from the word.
module tb_chip_serial_tx;

  localparam int W       = 8;
  localparam int DIVS[3] = '{4, 1, 2};
  localparam int MSBF[3] = '{1, 0, 1};

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] tx_data [3];
  logic         tx_valid[3];
  logic         tx_ready[3];
  logic         sdo     [3];
  logic         busy    [3];
  logic         done    [3];

  int checks = 0;
  int errors = 0;
  int gap;
  int idx;
  int prev_idx;

  always #5 clk = ~clk;

  chip_serial_tx #(.DATA_W(W), .DIV(4), .MSB_FIRST(1)) u_a (
    .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .sdo(sdo[0]), .busy(busy[0]), .done(done[0]));

  chip_serial_tx #(.DATA_W(W), .DIV(1), .MSB_FIRST(0)) u_b (
    .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .sdo(sdo[1]), .busy(busy[1]), .done(done[1]));

  chip_serial_tx #(.DATA_W(W), .DIV(2), .MSB_FIRST(1)) u_c (
    .clk(clk), .rst(rst), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .sdo(sdo[2]), .busy(busy[2]), .done(done[2]));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkIdle(input int i, input logic exp_done);
    checkOutput($sformatf("idle_sdo[%0d]", i), sdo[i], 1);
    checkOutput($sformatf("idle_ready[%0d]", i), tx_ready[i], 1);
    checkOutput($sformatf("idle_busy[%0d]", i), busy[i], 0);
    checkOutput($sformatf("idle_done[%0d]", i), done[i], exp_done);
  endtask

  // Called at a negedge with instance i idle. Returns at the negedge of the done cycle,
  // or right after releasing reset when abort_k hits.
  task automatic applyStimulus(input int i, input logic [W-1:0] word, input bit noise,
                               input logic [W-1:0] next_word, input int abort_k);
    int   div;
    int   n;
    int   b;
    int   di;
    logic exp_bit;
    div = DIVS[i];
    n   = (W + 2) * div;
    checkOutput($sformatf("ready_before[%0d]", i), tx_ready[i], 1);
    tx_data[i]  = word;
    tx_valid[i] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      b = k / div;
      if (b == 0) exp_bit = 1'b0;
      else if (b == W + 1) exp_bit = 1'b1;
      else begin
        di      = b - 1;
        exp_bit = (MSBF[i] != 0) ? word[W-1-di] : word[di];
      end
      checkOutput($sformatf("sdo[%0d] w=%0h k=%0d", i, word, k), sdo[i], exp_bit);
      checkOutput($sformatf("ready_busy[%0d] k=%0d", i, k), tx_ready[i], 0);
      checkOutput($sformatf("busy[%0d] k=%0d", i, k), busy[i], 1);
      checkOutput($sformatf("done_mid[%0d] k=%0d", i, k), done[i], 0);
      if (k == abort_k) begin
        #1 rst = 1'b1;
        #1;
        checkIdle(i, 1'b0);
        @(negedge clk);
        rst         = 1'b0;
        tx_valid[i] = 1'b0;
        return;
      end
      if (noise) begin
        tx_data[i]  = W'($urandom);
        tx_valid[i] = 1'($urandom_range(0, 1));
      end else begin
        tx_data[i]  = next_word;
        tx_valid[i] = 1'b1;
      end
      @(negedge clk);
    end
    checkIdle(i, 1'b1);
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tx_data[i]  = '0;
      tx_valid[i] = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) checkIdle(i, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) checkIdle(i, 1'b0);
    end

    $display("[TB] single frame 8'hA5, DIV=4, MSB first");
    applyStimulus(0, 8'hA5, 1'b0, 8'hA5, -1);
    tx_valid[0] = 1'b0;
    @(negedge clk);
    checkIdle(0, 1'b0);

    $display("[TB] single frame 8'h01, DIV=1, LSB first");
    applyStimulus(1, 8'h01, 1'b0, 8'h01, -1);
    tx_valid[1] = 1'b0;
    @(negedge clk);
    checkIdle(1, 1'b0);

    $display("[TB] back-to-back 8'h3C then 8'hC3, DIV=2");
    applyStimulus(2, 8'h3C, 1'b0, 8'hC3, -1);
    applyStimulus(2, 8'hC3, 1'b0, 8'hC3, -1);
    tx_valid[2] = 1'b0;
    @(negedge clk);
    checkIdle(2, 1'b0);

    $display("[TB] reset during third data bit of 8'hFF");
    applyStimulus(0, 8'hFF, 1'b0, 8'hFF, 3 * DIVS[0] + 1);
    repeat (3) begin
      @(negedge clk);
      checkIdle(0, 1'b0);
    end
    applyStimulus(0, 8'h00, 1'b0, 8'h00, -1);
    tx_valid[0] = 1'b0;
    @(negedge clk);
    checkIdle(0, 1'b0);

    $display("[TB] valid/data toggling while busy");
    applyStimulus(1, W'($urandom), 1'b1, 8'h00, -1);
    tx_valid[1] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkIdle(1, 1'b0);
    end

    $display("[TB] randomized frames");
    gap      = 1;
    prev_idx = 0;
    repeat (24) begin
      idx = (gap == 0) ? prev_idx : $urandom_range(0, 2);
      applyStimulus(idx, W'($urandom), 1'b1, 8'h00, -1);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        tx_valid[idx] = 1'b0;
        repeat (gap) begin
          @(negedge clk);
          checkIdle(idx, 1'b0);
        end
      end
      prev_idx = idx;
    end
    tx_valid[prev_idx] = 1'b0;
    @(negedge clk);
    checkIdle(prev_idx, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
